// File: rtl/mfsk_hbridge_gen_pkg.sv
// Shared definitions for the M-ary FSK H-bridge generator: FSM and bridge phase codes, byte stage type, width helper.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mfsk_hbridge_gen_pkg;

    // Top-level sequencer states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Bridge phases inside one symbol
    localparam logic [1:0] PH_DEAD = 2'd0;
    localparam logic [1:0] PH_A    = 2'd1;
    localparam logic [1:0] PH_B    = 2'd2;

    // One byte stage: payload plus occupancy flag
    typedef struct packed {
        logic       full;
        logic [7:0] dat;
    } byte_stage_t;

    // Bits needed to count 0..value-1, never less than one
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mfsk_hbridge_gen_tone.sv
// Square-wave H-bridge driver: DEAD, A_ON, DEAD, B_ON... with fixed dead time and diagonal non-overlap.
// Latency: gates are registered; the first cycle after a start edge is always a dead cycle.
// Backpressure: none; start restarts the sequence at once, enable low forces all gates off.
module mfsk_hbridge_gen_tone
    import mfsk_hbridge_gen_pkg::*;
#(
    parameter int PH_W      = 4,
    parameter int DEAD_CLKS = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [PH_W-1:0] half_period,
    input  logic            start,
    input  logic            enable,
    output logic            f1q1,
    output logic            f1q4,
    output logic            f2q2,
    output logic            f2q3
);

    // Counter reload values: cnt holds remaining cycles of the current phase minus one
    localparam logic [PH_W-1:0] DEAD_LAST = PH_W'(DEAD_CLKS - 1);
    localparam logic [PH_W-1:0] ON_SUB    = PH_W'(DEAD_CLKS + 1);

    logic [1:0]      phase_q, phase_d;
    logic            next_b_q, next_b_d;
    logic [PH_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0] half_q, half_d;
    logic            gate_a_q, gate_b_q;

    // Phase sequencing; a single phase register makes A and B mutually exclusive by construction
    always_comb begin
        phase_d  = phase_q;
        next_b_d = next_b_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        if (!enable) begin
            phase_d  = PH_DEAD;
            next_b_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            phase_d  = PH_DEAD;
            next_b_d = 1'b0;
            cnt_d    = DEAD_LAST;
            half_d   = half_period;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            case (phase_q)
                PH_DEAD: begin
                    phase_d = next_b_q ? PH_B : PH_A;
                    cnt_d   = half_q - ON_SUB;
                end
                PH_A: begin
                    phase_d  = PH_DEAD;
                    next_b_d = 1'b1;
                    cnt_d    = DEAD_LAST;
                end
                default: begin
                    phase_d  = PH_DEAD;
                    next_b_d = 1'b0;
                    cnt_d    = DEAD_LAST;
                end
            endcase
        end
    end

    // Phase state and registered diagonal drives
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q  <= PH_DEAD;
            next_b_q <= 1'b0;
            cnt_q    <= '0;
            half_q   <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            next_b_q <= next_b_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            gate_a_q <= (phase_d == PH_A);
            gate_b_q <= (phase_d == PH_B);
        end
    end

    // Both gates of a diagonal come from one flop, so they can never disagree
    assign f1q1 = gate_a_q;
    assign f1q4 = gate_a_q;
    assign f2q2 = gate_b_q;
    assign f2q3 = gate_b_q;

endmodule

// File: rtl/mfsk_hbridge_gen.sv
// M-ary FSK H-bridge generator: byte in over valid/ready, MSB-first symbols out as per-symbol bridge tones.
// Latency: byte accepted at edge N starts its first symbol (sym_start) at cycle N+2; back-to-back bytes have no gap.
// Backpressure: ready = !hold_full, registered; one holding stage behind the active shift register.
module mfsk_hbridge_gen
    import mfsk_hbridge_gen_pkg::*;
#(
    parameter int BITS_PER_SYM = 1,
    parameter int SYM_CLKS     = 416666,
    parameter int BASE_HALF    = 1000,
    parameter int STEP_HALF    = 100,
    parameter int DEAD_CLKS    = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    input  logic       abort,
    output logic       F1Q1,
    output logic       F1Q4,
    output logic       F2Q2,
    output logic       F2Q3,
    output logic       busy,
    output logic       sym_start
);

    localparam int NUM_TONES     = 1 << BITS_PER_SYM;
    localparam int SYMS_PER_BYTE = 8 / BITS_PER_SYM;
    localparam int SYM_W         = clog2(SYM_CLKS);
    localparam int PH_W          = clog2(BASE_HALF + (NUM_TONES - 1) * STEP_HALF + 1);

    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CLKS - 1);
    localparam logic [2:0]       IDX_LAST = 3'(SYMS_PER_BYTE - 1);

    logic [0:0]              state_q, state_d;
    byte_stage_t             hold_q, hold_d;
    logic [7:0]              act_q, act_d;
    logic [2:0]              sym_idx_q, sym_idx_d;
    logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic                    ready_q;
    logic                    sym_start_q;
    logic                    new_sym;
    logic [BITS_PER_SYM-1:0] sym_k;
    logic [PH_W-1:0]         half_sel;
    logic                    tone_en;

    // Sequencer: buffer transfer, symbol counting and shifting, abort flush
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        act_d     = act_q;
        sym_idx_d = sym_idx_q;
        sym_cnt_d = sym_cnt_q;
        new_sym   = 1'b0;
        if (abort) begin
            // Flush everything; an offered byte in the same cycle is dropped
            state_d   = ST_IDLE;
            hold_d    = '0;
            act_d     = '0;
            sym_idx_d = '0;
            sym_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_q.full) begin
                        act_d       = hold_q.dat;
                        hold_d.full = 1'b0;
                        sym_idx_d   = '0;
                        sym_cnt_d   = '0;
                        state_d     = ST_RUN;
                        new_sym     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sym_cnt_q != SYM_LAST) begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end else begin
                        sym_cnt_d = '0;
                        if (sym_idx_q != IDX_LAST) begin
                            act_d     = act_q << BITS_PER_SYM;
                            sym_idx_d = sym_idx_q + 3'd1;
                            new_sym   = 1'b1;
                        end else if (hold_q.full) begin
                            // Seamless reload: next byte's first symbol starts on the very next cycle
                            act_d       = hold_q.dat;
                            hold_d.full = 1'b0;
                            sym_idx_d   = '0;
                            new_sym     = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // ready is only high when HOLD is empty, so this never collides with a reload
            if (valid_in && ready_q) begin
                hold_d.full = 1'b1;
                hold_d.dat  = data_in;
            end
        end
    end

    // Tone of the symbol about to start: top bits of the (possibly freshly loaded) shift register
    always_comb begin
        sym_k    = act_d[7 -: BITS_PER_SYM];
        half_sel = PH_W'(BASE_HALF + int'(sym_k) * STEP_HALF);
        tone_en  = (state_d == ST_RUN);
    end

    // Sequencer state, buffers and registered handshake/marker outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            act_q       <= '0;
            sym_idx_q   <= '0;
            sym_cnt_q   <= '0;
            ready_q     <= 1'b1;
            sym_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            act_q       <= act_d;
            sym_idx_q   <= sym_idx_d;
            sym_cnt_q   <= sym_cnt_d;
            ready_q     <= !hold_d.full;
            sym_start_q <= new_sym;
        end
    end

    assign ready     = ready_q;
    assign busy      = (state_q == ST_RUN);
    assign sym_start = sym_start_q;

    mfsk_hbridge_gen_tone #(
        .PH_W      (PH_W),
        .DEAD_CLKS (DEAD_CLKS)
    ) u_tone (
        .clk         (clk),
        .rstn        (rstn),
        .half_period (half_sel),
        .start       (new_sym),
        .enable      (tone_en),
        .f1q1        (F1Q1),
        .f1q4        (F1Q4),
        .f2q2        (F2Q2),
        .f2q3        (F2Q3)
    );

endmodule
